// File: rtl/mips_uart_tx_if.sv
// Byte handshake between the MIPS debug unit (master) and the UART transmitter (slave).
interface mips_uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tx_ready;
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 o_tx;
  logic                 o_tx_done;

  modport master (
    output i_tx_ready,
    output i_tx_data,
    input  o_tx,
    input  o_tx_done
  );

  modport slave (
    input  i_tx_ready,
    input  i_tx_data,
    output o_tx,
    output o_tx_done
  );
endinterface

// File: rtl/mips_uart_tx.sv
// UART transmitter with internal oversample divider; serialises one byte per handshake
// and holds o_tx_done low for the whole frame.
module mips_uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 163,
  parameter int OS_TICKS   = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic            clk,
  input  logic            reset,
  mips_uart_tx_if.slave   bus
);

  localparam int DIV_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_MAX = (STOP_TICKS > OS_TICKS) ? STOP_TICKS : OS_TICKS;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = $clog2(DATA_BITS) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OS_TICKS - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [TICK_W-1:0]    r_tick;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_txDone;

  state_t               w_stateNext;
  logic [DIV_W-1:0]     w_divNext;
  logic [TICK_W-1:0]    w_tickNext;
  logic [BIT_W-1:0]     w_bitNext;
  logic [DATA_BITS-1:0] w_shiftNext;
  logic                 w_txNext;
  logic                 w_txDoneNext;
  logic                 w_baudTick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_txDone <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_div    <= w_divNext;
      r_tick   <= w_tickNext;
      r_bit    <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
      r_txDone <= w_txDoneNext;
    end
  end

  // Divider restarts on accept so the start bit is exactly OS_TICKS ticks wide.
  always_comb begin
    w_stateNext = r_state;
    w_divNext   = r_div;
    w_tickNext  = r_tick;
    w_bitNext   = r_bit;
    w_shiftNext = r_shift;
    w_baudTick  = (r_div == DIV_LAST);

    if (r_state != IDLE) begin
      w_divNext = w_baudTick ? '0 : r_div + 1'b1;
    end

    case (r_state)
      IDLE: begin
        w_divNext = '0;
        if (bus.i_tx_ready) begin
          w_stateNext = START;
          w_shiftNext = bus.i_tx_data;
          w_tickNext  = '0;
          w_bitNext   = '0;
        end
      end
      START: begin
        if (w_baudTick) begin
          if (r_tick == OS_LAST) begin
            w_tickNext  = '0;
            w_bitNext   = '0;
            w_stateNext = DATA;
          end else begin
            w_tickNext = r_tick + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_baudTick) begin
          if (r_tick == OS_LAST) begin
            w_tickNext  = '0;
            w_shiftNext = r_shift >> 1;
            if (r_bit == BIT_LAST) begin
              w_bitNext   = '0;
              w_stateNext = STOP;
            end else begin
              w_bitNext = r_bit + 1'b1;
            end
          end else begin
            w_tickNext = r_tick + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_baudTick) begin
          if (r_tick == STOP_LAST) begin
            w_tickNext  = '0;
            w_stateNext = IDLE;
          end else begin
            w_tickNext = r_tick + 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_divNext   = '0;
        w_tickNext  = '0;
        w_bitNext   = '0;
      end
    endcase

    // Line level is registered from the next state so it changes on the same edge as the state.
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      default: w_txNext = 1'b1;
    endcase
    w_txDoneNext = (w_stateNext == IDLE);
  end

  assign bus.o_tx      = r_tx;
  assign bus.o_tx_done = r_txDone;

endmodule
